// File: rtl/bus_arb_mux.sv
// N-to-1 request/response bus multiplexer with round-robin grant, single
// outstanding transaction, and response routing back to the granted master.
module bus_arb_mux #(
    parameter int PORTS  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORTS-1:0]           m_req_valid,
    output logic [PORTS-1:0]           m_req_ready,
    input  logic [PORTS*ADDR_W-1:0]    m_req_addr,
    input  logic [PORTS-1:0]           m_req_wen,
    input  logic [PORTS*DATA_W-1:0]    m_req_wdata,
    input  logic [PORTS*DATA_W/8-1:0]  m_req_wmask,
    output logic [PORTS-1:0]           m_rsp_valid,
    input  logic [PORTS-1:0]           m_rsp_ready,
    output logic [DATA_W-1:0]          m_rsp_rdata,
    output logic                       m_rsp_err,
    output logic                       s_req_valid,
    input  logic                       s_req_ready,
    output logic [ADDR_W-1:0]          s_req_addr,
    output logic                       s_req_wen,
    output logic [DATA_W-1:0]          s_req_wdata,
    output logic [DATA_W/8-1:0]        s_req_wmask,
    input  logic                       s_rsp_valid,
    output logic                       s_rsp_ready,
    input  logic [DATA_W-1:0]          s_rsp_rdata,
    input  logic                       s_rsp_err,
    output logic [$clog2(PORTS)-1:0]   owner,
    output logic                       busy,
    output logic [1:0]                 fsm_state
);
    localparam int OW = $clog2(PORTS);
    localparam int SW = DATA_W / 8;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; ready may depend combinationally on valid, never the reverse.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    state_t            state;
    logic [PORTS-1:0]  mask;
    logic [PORTS-1:0]  next_mask;
    logic [PORTS-1:0]  arb_mask;
    logic [PORTS-1:0]  masked_req;
    logic [OW-1:0]     pick;
    logic              any_req;
    logic              rsp_hs;

    function automatic logic [OW-1:0] lowest(input logic [PORTS-1:0] v);
        logic [OW-1:0] idx;
        idx = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (v[i]) idx = OW'(i);
        end
        return idx;
    endfunction

    // Ports above the one just served win first, then wrap to the lowest.
    always_comb begin
        next_mask = '0;
        for (int j = 0; j < PORTS; j++) begin
            next_mask[j] = (j > int'(owner));
        end
        arb_mask   = (state == RESP) ? next_mask : mask;
        masked_req = m_req_valid & arb_mask;
        pick       = (|masked_req) ? lowest(masked_req) : lowest(m_req_valid);
        any_req    = |m_req_valid;
        rsp_hs     = (state == RESP) && s_rsp_valid && m_rsp_ready[owner];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mask  <= '0;
            owner <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= pick;
                        busy  <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (s_req_ready) state <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        mask <= next_mask;
                        if (any_req) begin
                            owner <= pick;
                            state <= REQ;
                        end else begin
                            owner <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_req_ready = '0;
        m_rsp_valid = '0;
        s_req_valid = (state == REQ);
        s_rsp_ready = 1'b0;
        s_req_addr  = '0;
        s_req_wen   = 1'b0;
        s_req_wdata = '0;
        s_req_wmask = '0;
        m_rsp_rdata = '0;
        m_rsp_err   = 1'b0;
        fsm_state   = state;
        if (state == REQ) begin
            m_req_ready[owner] = s_req_ready;
            s_req_addr  = m_req_addr[int'(owner)*ADDR_W +: ADDR_W];
            s_req_wen   = m_req_wen[owner];
            s_req_wdata = m_req_wdata[int'(owner)*DATA_W +: DATA_W];
            s_req_wmask = m_req_wmask[int'(owner)*SW +: SW];
        end
        if (state == RESP) begin
            m_rsp_valid[owner] = s_rsp_valid;
            s_rsp_ready = m_rsp_ready[owner];
            m_rsp_rdata = s_rsp_rdata;
            m_rsp_err   = s_rsp_err;
        end
    end
endmodule

// File: tb/tb_bus_arb_mux.sv
// Bench for bus_arb_mux: bench-driven masters and slave, a transaction-level
// reference model, and a scoreboard checked by an independent monitor.
module tb_bus_arb_mux;
    localparam int PORTS = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int OW    = $clog2(PORTS);
    localparam int REQ_W = OW + AW + 1 + DW + SW;
    localparam int RSP_W = PORTS + DW + 1;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_RESP = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wmask;
    } txn_t;

    logic                   clk;
    logic                   rst;
    logic [PORTS-1:0]       m_req_valid;
    logic [PORTS-1:0]       m_req_ready;
    logic [PORTS*AW-1:0]    m_req_addr;
    logic [PORTS-1:0]       m_req_wen;
    logic [PORTS*DW-1:0]    m_req_wdata;
    logic [PORTS*SW-1:0]    m_req_wmask;
    logic [PORTS-1:0]       m_rsp_valid;
    logic [PORTS-1:0]       m_rsp_ready;
    logic [DW-1:0]          m_rsp_rdata;
    logic                   m_rsp_err;
    logic                   s_req_valid;
    logic                   s_req_ready;
    logic [AW-1:0]          s_req_addr;
    logic                   s_req_wen;
    logic [DW-1:0]          s_req_wdata;
    logic [SW-1:0]          s_req_wmask;
    logic                   s_rsp_valid;
    logic                   s_rsp_ready;
    logic [DW-1:0]          s_rsp_rdata;
    logic                   s_rsp_err;
    logic [OW-1:0]          owner;
    logic                   busy;
    logic [1:0]             fsm_state;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_arb_mux #(.PORTS(PORTS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_addr(m_req_addr), .m_req_wen(m_req_wen),
        .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_addr(s_req_addr), .s_req_wen(s_req_wen),
        .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
        .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err),
        .owner(owner), .busy(busy), .fsm_state(fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [REQ_W-1:0] exp_q[$];
    logic [RSP_W-1:0] exp_rsp_q[$];
    logic mon_en = 1'b0;

    // ---------------- reference model ----------------
    int ph   = PH_IDLE;
    int own  = 0;
    int last = PORTS - 1;
    txn_t mbuf [PORTS][8];
    int   mhead [PORTS];
    int   mcnt  [PORTS];

    int p_sready = 100, p_svalid = 100, p_mready = 100;
    int hold_sreq = 0, hold_mrsp = 0;
    logic          fix_valid = 1'b0;
    logic [DW-1:0] fix_rdata = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [PORTS-1:0] v, input int last_i);
        for (int k = 1; k <= PORTS; k++) begin
            int idx;
            idx = (last_i + k) % PORTS;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic pct(input int p);
        return ($urandom_range(99, 0) < p);
    endfunction

    task automatic push_txn(input int p, input logic [AW-1:0] a, input logic w,
                            input logic [DW-1:0] d, input logic [SW-1:0] m);
        txn_t t;
        t.addr = a; t.wen = w; t.wdata = d; t.wmask = m;
        if (mcnt[p] < 8) begin
            mbuf[p][(mhead[p] + mcnt[p]) % 8] = t;
            mcnt[p]++;
        end
    endtask

    task automatic push_rand(input int p);
        push_txn(p, $urandom, 1'($urandom_range(1, 0)), $urandom, SW'($urandom));
    endtask

    task automatic grant(input logic [PORTS-1:0] vld);
        own = rr_pick(vld, last);
        exp_q.push_back({OW'(own), mbuf[own][mhead[own]]});
        ph = PH_REQ;
    endtask

    // ---------------- driver ----------------
    task automatic zero_inputs();
        m_req_valid = '0; m_req_addr = '0; m_req_wen = '0;
        m_req_wdata = '0; m_req_wmask = '0; m_rsp_ready = '0;
        s_req_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_rdata = '0; s_rsp_err = 1'b0;
    endtask

    task automatic drive();
        logic [PORTS-1:0] oh;
        if (rst) begin
            zero_inputs();
            return;
        end
        for (int i = 0; i < PORTS; i++) begin
            txn_t t;
            if (mcnt[i] > 0) t = mbuf[i][mhead[i]];
            else t = {$urandom, 1'($urandom_range(1, 0)), $urandom, SW'($urandom)};
            m_req_valid[i] = (mcnt[i] > 0);
            m_req_addr[i*AW +: AW]  = t.addr;
            m_req_wen[i]            = t.wen;
            m_req_wdata[i*DW +: DW] = t.wdata;
            m_req_wmask[i*SW +: SW] = t.wmask;
            m_rsp_ready[i] = pct(p_mready);
        end
        if (ph == PH_REQ && hold_sreq > 0) begin
            s_req_ready = 1'b0;
            hold_sreq--;
        end else begin
            s_req_ready = pct(p_sready);
        end
        if (ph == PH_RESP && hold_mrsp > 0) begin
            m_rsp_ready[own] = 1'b0;
            hold_mrsp--;
        end
        s_rsp_valid = (ph == PH_RESP) ? pct(p_svalid) : pct(50);
        s_rsp_rdata = fix_valid ? fix_rdata : DW'($urandom);
        s_rsp_err   = fix_valid ? 1'b0 : 1'($urandom_range(1, 0));
        if (ph == PH_RESP && s_rsp_valid && m_rsp_ready[own]) begin
            oh = '0;
            oh[own] = 1'b1;
            exp_rsp_q.push_back({oh, s_rsp_rdata, s_rsp_err});
        end
    endtask

    // One clock: advance the model with the inputs of the cycle just ended,
    // then present the next cycle's inputs.
    task automatic step();
        logic [PORTS-1:0] vld;
        @(posedge clk);
        #1;
        vld = m_req_valid;
        if (rst) begin
            ph = PH_IDLE; own = 0; last = PORTS - 1;
        end else begin
            case (ph)
                PH_IDLE: if (|vld) grant(vld);
                PH_REQ: begin
                    if (s_req_ready) begin
                        ph = PH_RESP;
                        mhead[own] = (mhead[own] + 1) % 8;
                        mcnt[own]--;
                    end
                end
                default: begin
                    if (s_rsp_valid && m_rsp_ready[own]) begin
                        last = own;
                        if (|vld) grant(vld);
                        else begin
                            ph = PH_IDLE;
                            own = 0;
                        end
                    end
                end
            endcase
        end
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        zero_inputs();
        for (int i = 0; i < PORTS; i++) begin
            mcnt[i] = 0;
            mhead[i] = 0;
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        int pending;
        p_sready = 100; p_svalid = 100; p_mready = 100;
        n = 0;
        do begin
            step();
            n++;
            pending = 0;
            for (int i = 0; i < PORTS; i++) pending += mcnt[i];
        end while ((pending != 0 || ph != PH_IDLE) && n < 2000);
        if (pending != 0 || ph != PH_IDLE) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d after %0d cycles", pending, n);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [PORTS-1:0] e_rdy, e_rv;
        logic             e_srsp;
        logic [OW-1:0]    e_own;
        if (mon_en) begin
            e_rdy = '0;
            e_rv  = '0;
            e_srsp = 1'b0;
            if (ph == PH_REQ) e_rdy[own] = s_req_ready;
            if (ph == PH_RESP) begin
                e_rv[own] = s_rsp_valid;
                e_srsp = m_rsp_ready[own];
            end
            e_own = (ph != PH_IDLE) ? OW'(own) : '0;
            check("ctrl", {m_req_ready, m_rsp_valid, s_req_valid, s_rsp_ready, busy, owner},
                  {e_rdy, e_rv, (ph == PH_REQ), e_srsp, (ph != PH_IDLE), e_own});
            if (ph != PH_REQ)
                check("idle_payload", {s_req_addr, s_req_wen, s_req_wdata, s_req_wmask}, '0);
            if (s_req_valid && s_req_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got owner %0d addr %0h expected none", owner, s_req_addr);
                end else begin
                    check("req", {owner, s_req_addr, s_req_wen, s_req_wdata, s_req_wmask},
                          exp_q.pop_front());
                end
            end
            if (s_rsp_valid && s_rsp_ready) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got m_rsp_valid %0b expected none", m_rsp_valid);
                end else begin
                    check("rsp", {m_rsp_valid, m_rsp_rdata, m_rsp_err}, exp_rsp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b1;
        zero_inputs();
        for (int i = 0; i < PORTS; i++) begin
            mcnt[i] = 0;
            mhead[i] = 0;
        end
        do_reset();
        mon_en = 1'b1;
        run(3);

        // single read from port 0
        fix_valid = 1'b1;
        fix_rdata = 32'hDEAD_BEEF;
        push_txn(0, 32'h8000_0000, 1'b0, $urandom, 4'hF);
        run(6);
        fix_valid = 1'b0;
        drain();

        // continuous contention
        for (int k = 0; k < 4; k++) begin
            push_rand(0);
            push_rand(1);
        end
        drain();

        // write routed from port 1
        push_txn(1, 32'h0000_1000, 1'b1, 32'h1234_5678, 4'b0011);
        drain();

        // request and response backpressure
        hold_sreq = 3;
        hold_mrsp = 4;
        push_rand(0);
        push_rand(1);
        drain();

        // back-to-back re-request by port 0
        push_rand(0);
        push_rand(0);
        drain();

        // reset while in RESP
        p_svalid = 0;
        push_rand(0);
        n = 0;
        while (ph != PH_RESP && n < 20) begin
            step();
            n++;
        end
        check("reach_resp", (ph == PH_RESP), 1'b1);
        run(2);
        do_reset();
        push_rand(1);
        drain();

        // randomized traffic
        p_sready = 60; p_svalid = 60; p_mready = 70;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < PORTS; i++) begin
                if (mcnt[i] < 3 && $urandom_range(99, 0) < 30) push_rand(i);
            end
            step();
        end
        drain();
        run(3);

        check("req_q_left", exp_q.size(), 0);
        check("rsp_q_left", exp_rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
